ddr_tx_seq: RTL and testbench

DDR_TX_SEQ -- requirements
Module: ddr_tx_seq

---
 rtl/ddr_tx_seq.sv | 180 ++++++++++++++++++
 tb/tb_ddr_tx_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_tx_seq.sv
// Frame sequencer for a DDR-style serial transmitter: walks command, data-word and CRC
// phases, handing one mode code at a time to the serializer and advancing on its done pulse.
module ddr_tx_seq #(
    parameter int unsigned WC_W = 4
) (
    input  logic            i_sys_clk,
    input  logic            i_sys_rst,
    input  logic            i_start,
    input  logic            i_rnw,
    input  logic [WC_W-1:0] i_word_count,
    input  logic            i_end_restart,
    input  logic            i_abort,
    input  logic            i_tx_mode_done,
    output logic            o_tx_en,
    output logic [3:0]      o_tx_mode,
    output logic            o_regf_rd_en,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_aborted
);

    localparam logic [3:0] ModePre     = 4'b0000;
    localparam logic [3:0] ModeOne     = 4'b0010;
    localparam logic [3:0] ModeZero    = 4'b0110;
    localparam logic [3:0] ModeZeros   = 4'b0011;
    localparam logic [3:0] ModeAddr    = 4'b0001;
    localparam logic [3:0] ModePar     = 4'b0100;
    localparam logic [3:0] ModeData    = 4'b0111;
    localparam logic [3:0] ModeToken   = 4'b1100;
    localparam logic [3:0] ModeCrcv    = 4'b1101;
    localparam logic [3:0] ModeRestart = 4'b1111;
    localparam logic [3:0] ModeExit    = 4'b1110;

    typedef enum logic [4:0] {
        StIdle, StCPre, StCRnw, StCZeros, StCAddr, StCPar,
        StDP1, StDP0, StDB1, StDB2, StDPar,
        StKP0, StKP1, StKTok, StKCrc, StEnd, StFin
    } state_e;

    state_e          state_q, state_d;
    logic            rnw_q, rnw_d;
    logic            er_q, er_d;
    logic [WC_W-1:0] wc_q, wc_d;
    logic            abort_q, abort_d;

    logic            tx_en_q, tx_en_d;
    logic [3:0]      mode_q, mode_d;
    logic            rd_en_q, rd_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            abortable;

    always_comb begin
        state_d   = state_q;
        rnw_d     = rnw_q;
        er_d      = er_q;
        wc_d      = wc_q;
        abort_d   = abort_q;
        rd_en_d   = 1'b0;
        abortable = !(state_q inside {StIdle, StEnd, StFin});

        // Abort outranks a simultaneous mode-done: the frame is cut short right here.
        if (abortable && i_abort) begin
            state_d = StEnd;
            abort_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_d = StCPre;
                        rnw_d   = i_rnw;
                        er_d    = i_end_restart;
                        wc_d    = i_word_count;
                        abort_d = 1'b0;
                    end
                end
                StFin: begin
                    state_d = StIdle;
                    abort_d = 1'b0;
                end
                StCPre:   if (i_tx_mode_done) state_d = StCRnw;
                StCRnw:   if (i_tx_mode_done) state_d = StCZeros;
                StCZeros: if (i_tx_mode_done) state_d = StCAddr;
                StCAddr:  if (i_tx_mode_done) state_d = StCPar;
                StCPar: begin
                    if (i_tx_mode_done) begin
                        state_d = (rnw_q || wc_q == '0) ? StEnd : StDP1;
                    end
                end
                StDP1: if (i_tx_mode_done) state_d = StDP0;
                StDP0: if (i_tx_mode_done) state_d = StDB1;
                StDB1: begin
                    if (i_tx_mode_done) begin
                        state_d = StDB2;
                        rd_en_d = 1'b1;
                    end
                end
                StDB2: begin
                    if (i_tx_mode_done) begin
                        state_d = StDPar;
                        rd_en_d = 1'b1;
                    end
                end
                StDPar: begin
                    if (i_tx_mode_done) begin
                        // Zero test before decrement keeps the counter from wrapping.
                        if (wc_q != '0) begin
                            wc_d = wc_q - WC_W'(1);
                        end
                        state_d = (wc_q > WC_W'(1)) ? StDP1 : StKP0;
                    end
                end
                StKP0:  if (i_tx_mode_done) state_d = StKP1;
                StKP1:  if (i_tx_mode_done) state_d = StKTok;
                StKTok: if (i_tx_mode_done) state_d = StKCrc;
                StKCrc: if (i_tx_mode_done) state_d = StEnd;
                StEnd:  if (i_tx_mode_done) state_d = StFin;
                default: state_d = StIdle;
            endcase
        end

        // Outputs are decoded from the next state so they register in step with it.
        tx_en_d   = !(state_d inside {StIdle, StFin});
        busy_d    = tx_en_d;
        done_d    = (state_d == StFin);
        aborted_d = (state_d == StFin) && abort_d;

        unique case (state_d)
            StCPre:                 mode_d = ModePre;
            StCRnw:                 mode_d = rnw_d ? ModeOne : ModeZero;
            StCZeros:               mode_d = ModeZeros;
            StCAddr:                mode_d = ModeAddr;
            StCPar, StDPar:         mode_d = ModePar;
            StDP1, StKP1:           mode_d = ModeOne;
            StDP0, StKP0:           mode_d = ModeZero;
            StDB1, StDB2:           mode_d = ModeData;
            StKTok:                 mode_d = ModeToken;
            StKCrc:                 mode_d = ModeCrcv;
            StEnd:                  mode_d = (er_d && !abort_d) ? ModeRestart : ModeExit;
            default:                mode_d = 4'b0000;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q   <= StIdle;
            rnw_q     <= 1'b0;
            er_q      <= 1'b0;
            wc_q      <= '0;
            abort_q   <= 1'b0;
            tx_en_q   <= 1'b0;
            mode_q    <= 4'b0000;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnw_q     <= rnw_d;
            er_q      <= er_d;
            wc_q      <= wc_d;
            abort_q   <= abort_d;
            tx_en_q   <= tx_en_d;
            mode_q    <= mode_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_tx_en      = tx_en_q;
    assign o_tx_mode    = mode_q;
    assign o_regf_rd_en = rd_en_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_aborted    = aborted_q;

endmodule

// File: tb/tb_ddr_tx_seq.sv
// Directed bench for ddr_tx_seq: a frame-level mode-list model drives expectations that a
// single negedge monitor compares against the DUT outputs every cycle.
module tb_ddr_tx_seq;

    localparam int WC_W = 4;
    localparam logic [3:0] M_PRE = 4'b0000, M_ONE = 4'b0010, M_ZERO = 4'b0110;
    localparam logic [3:0] M_ZEROS = 4'b0011, M_ADDR = 4'b0001, M_PAR = 4'b0100;
    localparam logic [3:0] M_DATA = 4'b0111, M_TOKEN = 4'b1100, M_CRCV = 4'b1101;
    localparam logic [3:0] M_RESTART = 4'b1111, M_EXIT = 4'b1110;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0, rnw = 1'b0, end_restart = 1'b0;
    logic [WC_W-1:0] word_count = '0;
    logic            abort = 1'b0, mode_done = 1'b0;
    logic            tx_en, regf_rd_en, busy, done, aborted;
    logic [3:0]      tx_mode;

    // Expected outputs for the current cycle, maintained by the stimulus process.
    logic            exp_en = 1'b0, exp_rd = 1'b0, exp_done = 1'b0, exp_ab = 1'b0;
    logic [3:0]      exp_mode = 4'b0000;
    logic [3:0]      exp_q[$];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;

    // Literal checks are posted here and performed by the monitor.
    string pend_name;
    int    pend_act, pend_exp;
    int    pend_seq = 0;
    int    seen_seq = 0;

    ddr_tx_seq #(.WC_W(WC_W)) dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst_n),
        .i_start        (start),
        .i_rnw          (rnw),
        .i_word_count   (word_count),
        .i_end_restart  (end_restart),
        .i_abort        (abort),
        .i_tx_mode_done (mode_done),
        .o_tx_en        (tx_en),
        .o_tx_mode      (tx_mode),
        .o_regf_rd_en   (regf_rd_en),
        .o_busy         (busy),
        .o_done         (done),
        .o_aborted      (aborted)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        chk("tx_en", int'(tx_en), int'(exp_en));
        chk("busy", int'(busy), int'(exp_en));
        chk("done", int'(done), int'(exp_done));
        chk("aborted", int'(aborted), int'(exp_ab));
        chk("regf_rd_en", int'(regf_rd_en), int'(exp_rd));
        if (exp_en) chk("tx_mode", int'(tx_mode), int'(exp_mode));
        if (regf_rd_en) rd_cnt++;
        if (pend_seq != seen_seq) begin
            seen_seq = pend_seq;
            chk(pend_name, pend_act, pend_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input string name, input int act, input int exp);
        pend_name = name;
        pend_act  = act;
        pend_exp  = exp;
        pend_seq++;
        step();
    endtask

    // Mode list of a complete, unaborted frame straight from the frame rules.
    function automatic void build(input logic r, input int wc, input logic er);
        exp_q.delete();
        exp_q.push_back(M_PRE);
        exp_q.push_back(r ? M_ONE : M_ZERO);
        exp_q.push_back(M_ZEROS);
        exp_q.push_back(M_ADDR);
        exp_q.push_back(M_PAR);
        if (!r && wc > 0) begin
            for (int w = 0; w < wc; w++) begin
                exp_q.push_back(M_ONE);
                exp_q.push_back(M_ZERO);
                exp_q.push_back(M_DATA);
                exp_q.push_back(M_DATA);
                exp_q.push_back(M_PAR);
            end
            exp_q.push_back(M_ZERO);
            exp_q.push_back(M_ONE);
            exp_q.push_back(M_TOKEN);
            exp_q.push_back(M_CRCV);
        end
        exp_q.push_back(er ? M_RESTART : M_EXIT);
    endfunction

    // ab_at / rst_at: mode index at which to abort / reset (-1 = never).
    task automatic run_frame(input string tag, input logic r, input int wc, input logic er,
                             input int ab_at, input logic ab_done, input int rst_at,
                             input int exp_len, input int exp_rds);
        int   k = 0;
        int   base;
        logic ab = 1'b0;
        logic fin = 1'b0;
        logic is_end;
        build(r, wc, er);
        post({tag, "_len"}, exp_q.size(), exp_len);
        base        = rd_cnt;
        rnw         = r;
        word_count  = wc[WC_W-1:0];
        end_restart = er;
        start       = 1'b1;
        step();
        start       = 1'b0;
        // Scramble the frame inputs to prove they were latched.
        rnw         = ~r;
        end_restart = ~er;
        word_count  = '0;
        exp_en      = 1'b1;
        exp_mode    = exp_q[0];
        while (!fin) begin
            is_end = ab || (k == exp_q.size() - 1);
            if (k == rst_at) begin
                step();
                rst_n    = 1'b0;
                exp_en   = 1'b0;
                exp_rd   = 1'b0;
                exp_done = 1'b0;
                exp_ab   = 1'b0;
                repeat (2) step();
                rst_n = 1'b1;
                step();
                fin = 1'b1;
            end else begin
                start = 1'b1;
                step();
                start  = 1'b0;
                exp_rd = 1'b0;
                if (is_end) abort = 1'b1;
                step();
                abort = 1'b0;
                if (k == ab_at && !ab) begin
                    abort     = 1'b1;
                    mode_done = ab_done;
                    step();
                    abort     = 1'b0;
                    mode_done = 1'b0;
                    ab        = 1'b1;
                    exp_mode  = M_EXIT;
                end else begin
                    mode_done = 1'b1;
                    step();
                    mode_done = 1'b0;
                    if (is_end) begin
                        exp_en   = 1'b0;
                        exp_done = 1'b1;
                        exp_ab   = ab;
                        step();
                        exp_done = 1'b0;
                        exp_ab   = 1'b0;
                        fin      = 1'b1;
                    end else begin
                        exp_rd   = (exp_q[k] == M_DATA);
                        k++;
                        exp_mode = exp_q[k];
                    end
                end
            end
        end
        post({tag, "_rd_pulses"}, rd_cnt - base, exp_rds);
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();
        // Done and abort while idle must not start anything.
        mode_done = 1'b1;
        abort     = 1'b1;
        step();
        mode_done = 1'b0;
        abort     = 1'b0;
        repeat (2) step();

        run_frame("read",       1'b1, 5,  1'b0, -1, 1'b0, -1, 6,  0);
        run_frame("write2",     1'b0, 2,  1'b1, -1, 1'b0, -1, 20, 4);
        run_frame("write0",     1'b0, 0,  1'b1, -1, 1'b0, -1, 6,  0);
        run_frame("abort_db2",  1'b0, 3,  1'b1, 8,  1'b0, -1, 25, 1);
        run_frame("abort_addr", 1'b0, 1,  1'b0, 3,  1'b1, -1, 15, 0);
        run_frame("reset_db1",  1'b0, 1,  1'b0, -1, 1'b0, 7,  15, 0);
        run_frame("read_er",    1'b1, 0,  1'b1, -1, 1'b0, -1, 6,  0);
        run_frame("write15",    1'b0, 15, 1'b0, -1, 1'b0, -1, 85, 30);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
